// File: rtl/fir_regs_pkg.sv
// Shared register map, command bits and CONFIG layout for the FIR correlator
// register file.
package fir_regs_pkg;

    localparam logic [6:0] REG_CONFIG  = 7'd0;
    localparam logic [6:0] REG_COMMAND = 7'd1;
    localparam logic [6:0] REG_STATUS  = 7'd2;
    localparam logic [6:0] REG_WEIGHT  = 7'd3;

    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;
    localparam int CMD_FLUSH = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic       mode;
        logic [3:0] taps;
        logic [3:0] shift;
        logic [7:0] ac_delay;
        logic [6:0] rsvd;
        logic [7:0] last_tap;
    } fir_cfg_t;

endpackage

// File: rtl/fir_axil_regs.sv
// AXI4-Lite register file for the FIR correlator: held CONFIG word, command
// pulses, streamed coefficient writes and a STATUS readback.
module fir_axil_regs
    import fir_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            cfg_mode,
    output logic [3:0]                      cfg_taps,
    output logic [3:0]                      cfg_shift,
    output logic [7:0]                      cfg_ac_delay,
    output logic [7:0]                      cfg_last_tap,
    output logic                            cmd_start,
    output logic                            cmd_stop,
    output logic                            cmd_flush,
    output logic                            run,
    output logic                            coef_we,
    output logic [7:0]                      coef_addr,
    output logic [31:0]                     coef_data
);

    fir_cfg_t    cfg_q, cfg_d;
    logic        awready_q, awready_d;
    logic [6:0]  awidx_q, awidx_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        run_q, run_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [8:0]  count_q, count_d;
    logic        full_q, full_d;
    logic        coef_we_q, coef_we_d;
    logic [7:0]  coef_addr_q, coef_addr_d;
    logic [31:0] coef_data_q, coef_data_d;
    logic        start_q, start_d, stop_q, stop_d, flush_q, flush_d;

    logic [6:0]  aw_idx, ar_idx;
    logic        unused_addr_bits;

    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        awready_d   = 1'b0;
        awidx_d     = awidx_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        cfg_d       = cfg_q;
        run_d       = run_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        full_d      = full_q;
        coef_we_d   = 1'b0;
        coef_addr_d = coef_addr_q;
        coef_data_d = coef_data_q;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        flush_d     = 1'b0;

        if (bvalid_q && S_AXI_BREADY)
            bvalid_d = 1'b0;

        // Readies go out one cycle after both valids; WDATA is taken a cycle later.
        if (!awready_q && !bvalid_q && S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_d = 1'b1;
            awidx_d   = aw_idx;
        end

        if (awready_q) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (awidx_q)
                REG_CONFIG: begin
                    if (run_q) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        cfg_d      = fir_cfg_t'(S_AXI_WDATA);
                        cfg_d.rsvd = '0;
                        ptr_d      = '0;
                        count_d    = '0;
                        full_d     = 1'b0;
                    end
                end
                REG_COMMAND: begin
                    if (S_AXI_WDATA[CMD_START] && S_AXI_WDATA[CMD_STOP]) begin
                        run_d   = 1'b0;
                        ptr_d   = '0;
                        count_d = '0;
                        full_d  = 1'b0;
                    end else if (S_AXI_WDATA[CMD_START]) begin
                        run_d   = 1'b1;
                        start_d = 1'b1;
                    end else if (S_AXI_WDATA[CMD_STOP]) begin
                        run_d  = 1'b0;
                        stop_d = 1'b1;
                    end
                    flush_d = S_AXI_WDATA[CMD_FLUSH];
                end
                REG_WEIGHT: begin
                    if (full_q || run_q) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        coef_we_d   = 1'b1;
                        coef_addr_d = ptr_q;
                        coef_data_d = S_AXI_WDATA;
                        ptr_d       = ptr_q + 8'd1;
                        count_d     = count_q + 9'd1;
                        if (ptr_q == cfg_q.last_tap)
                            full_d = 1'b1;
                    end
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end
    end

    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (arready_q)
            rvalid_d = 1'b1;
        else if (rvalid_q && S_AXI_RREADY)
            rvalid_d = 1'b0;

        // Read data is captured on the ARREADY edge and held until RREADY.
        if (S_AXI_ARVALID && !rvalid_q && !arready_q) begin
            arready_d = 1'b1;
            rresp_d   = RESP_OKAY;
            case (ar_idx)
                REG_CONFIG:             rdata_d = cfg_q;
                REG_COMMAND,
                REG_WEIGHT:             rdata_d = '0;
                REG_STATUS:             rdata_d = {run_q, full_q, 21'd0, count_q};
                default: begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q       <= '0;
            awready_q   <= 1'b0;
            awidx_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            run_q       <= 1'b0;
            ptr_q       <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            awready_q   <= awready_d;
            awidx_q     <= awidx_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            run_q       <= run_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            coef_we_q   <= coef_we_d;
            coef_addr_q <= coef_addr_d;
            coef_data_q <= coef_data_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            flush_q     <= flush_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign cfg_mode      = cfg_q.mode;
    assign cfg_taps      = cfg_q.taps;
    assign cfg_shift     = cfg_q.shift;
    assign cfg_ac_delay  = cfg_q.ac_delay;
    assign cfg_last_tap  = cfg_q.last_tap;
    assign cmd_start     = start_q;
    assign cmd_stop      = stop_q;
    assign cmd_flush     = flush_q;
    assign run           = run_q;
    assign coef_we       = coef_we_q;
    assign coef_addr     = coef_addr_q;
    assign coef_data     = coef_data_q;

endmodule

// File: tb/tb_fir_axil_regs.sv
// Bench for fir_axil_regs: directed scenarios plus random traffic checked
// against a transaction-level model of the register file.
module tb_fir_axil_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [8:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        cfg_mode;
    logic [3:0]  cfg_taps;
    logic [3:0]  cfg_shift;
    logic [7:0]  cfg_ac_delay;
    logic [7:0]  cfg_last_tap;
    logic        cmd_start, cmd_stop, cmd_flush, run, coef_we;
    logic [7:0]  coef_addr;
    logic [31:0] coef_data;

    fir_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(9)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .cfg_mode(cfg_mode), .cfg_taps(cfg_taps), .cfg_shift(cfg_shift),
        .cfg_ac_delay(cfg_ac_delay), .cfg_last_tap(cfg_last_tap),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_flush(cmd_flush), .run(run),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: CONFIG word, run level and number of weights loaded since the last clear.
    logic [31:0] m_cfg = '0;
    logic        m_run = 1'b0;
    int          m_count = 0;
    logic        e_we = 1'b0, e_start = 1'b0, e_stop = 1'b0, e_flush = 1'b0;
    logic [7:0]  e_waddr = '0;
    logic [31:0] e_wdata = '0;
    int          we_seen = 0, start_seen = 0, stop_seen = 0, flush_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_full();
        return m_count == int'(m_cfg[7:0]) + 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [6:0] idx, output logic [1:0] resp);
        resp = 2'b00;
        case (idx)
            7'd0:       return m_cfg;
            7'd1, 7'd3: return 32'h0;
            7'd2:       return {m_run, m_full(), 21'h0, 9'(m_count)};
            default: begin
                resp = 2'b10;
                return 32'h0;
            end
        endcase
    endfunction

    task automatic model_write(input logic [6:0] idx, input logic [31:0] d, output logic [1:0] resp);
        resp = 2'b00;
        case (idx)
            7'd0: begin
                if (m_run) resp = 2'b10;
                else begin
                    m_cfg   = d & 32'hFFFF_80FF;
                    m_count = 0;
                end
            end
            7'd1: begin
                if (d[0] && d[1]) begin
                    m_run   = 1'b0;
                    m_count = 0;
                end else if (d[0]) begin
                    m_run   = 1'b1;
                    e_start = 1'b1;
                end else if (d[1]) begin
                    m_run  = 1'b0;
                    e_stop = 1'b1;
                end
                e_flush = d[3];
            end
            7'd3: begin
                if (m_run || m_full()) resp = 2'b10;
                else begin
                    e_we    = 1'b1;
                    e_waddr = 8'(m_count % 256);
                    e_wdata = d;
                    m_count++;
                end
            end
            default: resp = 2'b10;
        endcase
    endtask

    task automatic clear_pulses();
        e_we = 1'b0; e_start = 1'b0; e_stop = 1'b0; e_flush = 1'b0;
    endtask

    task automatic model_reset();
        m_cfg = '0; m_run = 1'b0; m_count = 0;
        clear_pulses();
    endtask

    // Called and returns at one time unit after a rising edge.
    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                             input int wdelay, input int bdelay, output logic [1:0] resp);
        logic [1:0] e_resp;
        int n;
        resp = 2'b11;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = (wdelay == 0) ? data : ~data;
        S_AXI_WVALID  = (wdelay == 0);
        if (wdelay != 0) begin
            @(posedge clk); #1;
            chk("aw_only_no_ready", S_AXI_AWREADY, 1'b0);
            S_AXI_WDATA  = data;
            S_AXI_WVALID = 1'b1;
        end
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!S_AXI_AWREADY && n < 20);
        chk("aw_latency", n, 1);
        if (!S_AXI_AWREADY) begin
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
            return;
        end
        chk("ready_pair", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        model_write(addr[8:2], data, e_resp);
        chk("bvalid_rise", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
        S_AXI_BREADY = (bdelay == 0);
        for (int k = 0; k < bdelay; k++) begin
            S_AXI_AWVALID = 1'b1;
            S_AXI_WVALID  = 1'b1;
            @(posedge clk); #1;
            clear_pulses();
            chk("bvalid_hold_aw_blocked", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        clear_pulses();
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", S_AXI_BVALID, 1'b0);
        chk("bresp", resp, e_resp);
    endtask

    task automatic axi_read(input logic [8:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        int n;
        data = '0;
        resp = 2'b11;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!S_AXI_ARREADY && n < 20);
        S_AXI_ARVALID = 1'b0;
        chk("ar_latency", n, 1);
        if (!S_AXI_ARREADY) return;
        e_data = m_read(addr[8:2], e_resp);
        @(posedge clk); #1;
        chk("rvalid_rise", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b10);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int k = 0; k < rdelay; k++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, data});
        end
        S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", S_AXI_RVALID, 1'b0);
        chk("rdata", data, e_data);
        chk("rresp", resp, e_resp);
    endtask

    // Every-cycle comparison of the core-facing outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cfg_out", {cfg_mode, cfg_taps, cfg_shift, cfg_ac_delay, cfg_last_tap},
                {m_cfg[31:15], m_cfg[7:0]});
            chk("run_out", run, m_run);
            chk("pulses", {coef_we, cmd_start, cmd_stop, cmd_flush}, {e_we, e_start, e_stop, e_flush});
            if (e_we) chk("coef_port", {coef_addr, coef_data}, {e_waddr, e_wdata});
            chk("ready_pair_eq", S_AXI_AWREADY, S_AXI_WREADY);
            we_seen    += int'(coef_we);
            start_seen += int'(cmd_start);
            stop_seen  += int'(cmd_stop);
            flush_seen += int'(cmd_flush);
        end
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] rd;
        logic [31:0] d;
        int w0, s0, p0, f0, n, op;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
             S_AXI_RRESP, S_AXI_RVALID, cfg_mode, cfg_taps, cfg_shift, cfg_ac_delay, cfg_last_tap,
             cmd_start, cmd_stop, cmd_flush, run, coef_we, coef_addr, coef_data}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        axi_write(9'h000, 32'h7D00_007F, 1, 0, r);
        chk("cfg_wr_okay", r, 2'b00);
        chk("cfg_fields", {cfg_mode, cfg_taps, cfg_shift, cfg_ac_delay, cfg_last_tap},
            {1'b0, 4'd15, 4'd10, 8'd0, 8'd127});
        axi_read(9'h000, 2, rd, r);
        chk("cfg_readback", rd, 32'h7D00_007F);

        w0 = we_seen;
        for (int i = 0; i < 128; i++) axi_write(9'h00C, 32'h0001_0002 + i, 0, 0, r);
        chk("strobes_128", we_seen - w0, 128);
        axi_read(9'h008, 0, rd, r);
        chk("status_full_128", rd, 32'h4000_0080);
        axi_write(9'h00C, 32'h1234_5678, 0, 0, r);
        chk("weight_when_full", r, 2'b10);

        axi_write(9'h000, 32'h7D00_007E, 0, 0, r);
        w0 = we_seen;
        for (int i = 0; i < 128; i++) axi_write(9'h00C, 32'hABCD_0000 + i, 0, 0, r);
        chk("strobes_127", we_seen - w0, 127);
        chk("weight_128th_slverr", r, 2'b10);
        axi_read(9'h008, 0, rd, r);
        chk("status_full_127", rd, 32'h4000_007F);

        s0 = start_seen; p0 = stop_seen; f0 = flush_seen;
        axi_write(9'h004, 32'h1, 0, 0, r);
        chk("start_pulse_run", {start_seen - s0, 31'(run)}, {32'd1, 31'd1});
        axi_write(9'h00C, 32'h5555_5555, 0, 0, r);
        chk("weight_while_run", r, 2'b10);
        axi_write(9'h000, 32'h1234_5678, 0, 0, r);
        chk("cfg_while_run", r, 2'b10);
        axi_read(9'h000, 0, rd, r);
        chk("cfg_kept_run", rd, 32'h7D00_007E);
        axi_write(9'h004, 32'h2, 0, 0, r);
        chk("stop_pulse_run", {stop_seen - p0, 31'(run)}, {32'd1, 31'd0});
        axi_write(9'h004, 32'h8, 0, 0, r);
        chk("flush_only", {flush_seen - f0, start_seen - s0, stop_seen - p0}, {32'd1, 32'd1, 32'd1});

        axi_write(9'h004, 32'h1, 0, 0, r);
        s0 = start_seen; p0 = stop_seen;
        axi_write(9'h004, 32'h3, 0, 0, r);
        chk("soft_reset_no_pulse", {start_seen - s0, stop_seen - p0, 31'(run)}, '0);
        axi_read(9'h008, 0, rd, r);
        chk("status_after_soft", rd, 32'h0);
        axi_read(9'h000, 0, rd, r);
        chk("cfg_after_soft", rd, 32'h7D00_007E);
        axi_read(9'h014, 0, rd, r);
        chk("unmapped_read", {rd, r}, {32'h0, 2'b10});
        axi_write(9'h008, 32'hFFFF_FFFF, 0, 0, r);
        chk("status_write_slverr", r, 2'b10);
        axi_write(9'h000, 32'hFFFF_FFFF, 0, 10, r);
        axi_read(9'h000, 0, rd, r);
        chk("cfg_reserved_zero", rd, 32'hFFFF_80FF);

        // Reset while a write response is pending.
        S_AXI_AWADDR = 9'h008; S_AXI_WDATA = 32'hDEAD_BEEF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!S_AXI_AWREADY && n < 20);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_outputs",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RDATA,
             S_AXI_RRESP, S_AXI_RVALID, cfg_mode, cfg_taps, cfg_shift, cfg_ac_delay, cfg_last_tap,
             cmd_start, cmd_stop, cmd_flush, run, coef_we, coef_addr, coef_data}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_resp_after_rst", S_AXI_BVALID, 1'b0);
        axi_write(9'h000, 32'h0080_0005, 0, 0, r);
        chk("post_rst_cfg_okay", r, 2'b00);
        axi_read(9'h000, 0, rd, r);
        chk("post_rst_cfg_read", rd, 32'h0080_0005);

        for (int t = 0; t < 400; t++) begin
            op = $urandom_range(0, 99);
            if (op < 10) begin
                d = $urandom;
                d[7:0] = 8'($urandom_range(0, 5));
                axi_write({7'd0, 2'($urandom)}, d, $urandom_range(0, 1), $urandom_range(0, 2), r);
            end else if (op < 25) begin
                d = $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) d = d | ($urandom & 32'hFFFF_FFF0);
                axi_write({7'd1, 2'($urandom)}, d, $urandom_range(0, 1), $urandom_range(0, 2), r);
            end else if (op < 65) begin
                axi_write({7'd3, 2'($urandom)}, $urandom, $urandom_range(0, 1), $urandom_range(0, 1), r);
            end else if (op < 70) begin
                d = (($urandom_range(0, 1) == 0) ? 32'd2 : 32'($urandom_range(4, 127)));
                axi_write({d[6:0], 2'($urandom)}, $urandom, 0, 0, r);
            end else begin
                d = $urandom_range(0, 7);
                axi_read({d[6:0], 2'($urandom)}, $urandom_range(0, 2), rd, r);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
